// File: rtl/binary_count_checker.sv
// binary_count_checker
//   Watches a 4-bit synchronous binary counter running on the same clock and
//   confirms that every sample is the previous sample +1 (mod 16). It emits a
//   one-cycle wrap_tick on each 15->0 step and keeps a running wrap count. It
//   latches sequence jumps and stalls as sticky errors until clr_err is
//   pulsed while in FAULT.
//
//   Build option: define COUNT_CHECK_IRQ_EN to add a registered irq output,
//   which mirrors seq_err | stall_err. Without the macro, irq does not exist.
//
// Parameters
//   WRAP_W       width of wrap_count (wraps modulo 2^WRAP_W)
//   STALL_W      width of the internal stall counter
//   STALL_LIMIT  number of consecutive repeated samples that raise stall_err
//                (legal range 1 .. 2^STALL_W-1)
//
// Ports
//   clk          single clock, shared with the counter
//   reset        asynchronous, active-high
//   Qa..Qd       counter bits, Qa = LSB, Qd = MSB
//   clr_err      in FAULT: clear sticky errors and resync through IDLE
//   wrap_tick    one-cycle pulse per 15->0 transition
//   wrap_count   wraps seen since reset
//   seq_err      sticky: sample was neither prev+1 nor prev
//   stall_err    sticky: STALL_LIMIT consecutive repeated samples
//   last_count   previous registered sample
//   state        IDLE=0, TRACK=1, FAULT=2
//   irq          (COUNT_CHECK_IRQ_EN only) seq_err | stall_err, registered

module binary_count_checker #(
  parameter int WRAP_W      = 8,
  parameter int STALL_W     = 3,
  parameter int STALL_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Qa,
  input  logic              Qb,
  input  logic              Qc,
  input  logic              Qd,
  input  logic              clr_err,
  output logic              wrap_tick,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              seq_err,
  output logic              stall_err,
  output logic [3:0]        last_count,
  output logic [1:0]        state
`ifdef COUNT_CHECK_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [3:0]         cnt;
  logic [3:0]         prev_inc;
  logic               step_ok;    // sample is prev+1 (4-bit wrap)
  logic               step_hold;  // sample repeats prev
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_inc;
  logic               stall_hit;

  logic [1:0]         state_nxt;
  logic               tick_nxt;
  logic [WRAP_W-1:0]  wcnt_nxt;
  logic               seq_nxt;
  logic               stall_err_nxt;
  logic [STALL_W-1:0] stall_nxt;

  assign cnt       = {Qd, Qc, Qb, Qa};
  assign prev_inc  = last_count + 4'd1;
  assign step_ok   = (cnt == prev_inc);
  assign step_hold = (cnt == last_count);
  assign stall_inc = stall_cnt + STALL_W'(1);
  assign stall_hit = (stall_inc == STALL_W'(STALL_LIMIT));

  // State register plus all registered outputs. prev follows the counter on
  // every edge regardless of state, so IDLE always resyncs to the live value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_count <= '0;
      wrap_count <= '0;
      wrap_tick  <= 1'b0;
      seq_err    <= 1'b0;
      stall_err  <= 1'b0;
      stall_cnt  <= '0;
`ifdef COUNT_CHECK_IRQ_EN
      irq        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      last_count <= cnt;
      wrap_count <= wcnt_nxt;
      wrap_tick  <= tick_nxt;
      seq_err    <= seq_nxt;
      stall_err  <= stall_err_nxt;
      stall_cnt  <= stall_nxt;
`ifdef COUNT_CHECK_IRQ_EN
      // Built from the next flag values so irq rises and falls with the flags.
      irq        <= seq_nxt | stall_err_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = S_TRACK;
      S_TRACK: begin
        if (step_ok)                     state_nxt = S_TRACK;
        else if (step_hold && !stall_hit) state_nxt = S_TRACK;
        else                             state_nxt = S_FAULT;
      end
      S_FAULT: state_nxt = clr_err ? S_IDLE : S_FAULT;
      default: state_nxt = S_IDLE;  // encoding 3 recovers through IDLE
    endcase
  end

  // Output / datapath logic
  always_comb begin
    tick_nxt      = 1'b0;
    wcnt_nxt      = wrap_count;
    seq_nxt       = seq_err;
    stall_err_nxt = stall_err;
    stall_nxt     = stall_cnt;
    case (state)
      S_TRACK: begin
        if (step_ok) begin
          stall_nxt = '0;
          // step_ok with prev==15 implies cnt==0
          if (last_count == 4'd15) begin
            tick_nxt = 1'b1;
            wcnt_nxt = wrap_count + WRAP_W'(1);
          end
        end else if (step_hold) begin
          stall_nxt = stall_inc;
          if (stall_hit) stall_err_nxt = 1'b1;
        end else begin
          seq_nxt   = 1'b1;
          stall_nxt = '0;
        end
      end
      S_FAULT: begin
        if (clr_err) begin
          seq_nxt       = 1'b0;
          stall_err_nxt = 1'b0;
          stall_nxt     = '0;
        end
      end
      default: ;
    endcase
  end

endmodule
